// File: rtl/slice_sequencer.sv
// ----------------------------------------------------------------------------
// slice_sequencer
//
// Purpose:
//   Cuts one measured item into slice_num_o equal pieces. It latches the item
//   length, divides it by the slice count using a bit-serial restoring divider,
//   and then alternates feeder (move) and cutter (cut) requests once per piece.
//   A pause flag holds off new requests but lets an outstanding one finish.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   start_i           start a job (honoured in IDLE only)
//   pause_i           toggle the paused flag (ignored in IDLE)
//   slice_i           increment slice count, MAX_SLICE wraps to 1 (IDLE only)
//   distance_i        item length in steps
//   distance_valid_i  qualifier for distance_i
//   move_req_o        feeder request level
//   move_steps_o      steps per piece, stable while move_req_o is high
//   move_done_i       feeder completion pulse
//   cut_req_o         cutter request level
//   cut_done_i        cutter completion pulse
//   slice_num_o       current slice count
//   busy_o            high outside IDLE
//   paused_o          paused flag
//   finish_o          one-cycle job completion pulse
//   err_o             piece length computed as zero; cleared by next start
//
// States:
//   IDLE      | waiting for start, slice count may be edited
//   WAIT_DIST | waiting for a qualified length measurement
//   DIVIDE    | one restoring-division quotient bit per cycle, DIST_W cycles
//   MOVE      | issue feeder request unless paused
//   MOVE_WAIT | feeder request outstanding
//   CUT       | issue cutter request unless paused
//   CUT_WAIT  | cutter request outstanding
//   DONE      | one-cycle finish pulse
// ----------------------------------------------------------------------------
module slice_sequencer #(
    parameter int DIST_W    = 17,
    parameter int MAX_SLICE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              slice_i,
    input  logic [DIST_W-1:0] distance_i,
    input  logic              distance_valid_i,
    output logic              move_req_o,
    output logic [DIST_W-1:0] move_steps_o,
    input  logic              move_done_i,
    output logic              cut_req_o,
    input  logic              cut_done_i,
    output logic [4:0]        slice_num_o,
    output logic              busy_o,
    output logic              paused_o,
    output logic              finish_o,
    output logic              err_o
);

    localparam int CNT_W = (DIST_W > 1) ? $clog2(DIST_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DIST,
        S_DIVIDE,
        S_MOVE,
        S_MOVE_WAIT,
        S_CUT,
        S_CUT_WAIT,
        S_DONE
    } state_t;

    state_t            state_q,    state_d;
    logic [4:0]        slice_q,    slice_d;
    logic [DIST_W-1:0] len_q,      len_d;
    logic [DIST_W-1:0] piece_q,    piece_d;
    logic [4:0]        remain_q,   remain_d;
    logic [4:0]        rem_q,      rem_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              move_req_q, move_req_d;
    logic              cut_req_q,  cut_req_d;
    logic              paused_q,   paused_d;
    logic              err_q,      err_d;

    // Restoring division step: the partial remainder is always below the
    // divisor (at most 31), so 5 bits hold it and the trial value needs 6.
    logic [5:0]        trial;
    logic [5:0]        divisor;
    logic [5:0]        diff;
    logic              q_bit;
    logic [4:0]        rem_next;
    logic [DIST_W-1:0] piece_shift;

    always_comb begin
        trial       = {rem_q, len_q[cnt_q]};
        divisor     = {1'b0, slice_q};
        diff        = trial - divisor;
        q_bit       = (trial >= divisor);
        rem_next    = q_bit ? diff[4:0] : trial[4:0];
        piece_shift = {piece_q[DIST_W-2:0], q_bit};
    end

    // A pause pulse arriving in the issue cycle already counts, so issue
    // decisions look at the flag as it will be after this edge.
    logic paused_eff;

    always_comb begin
        state_d    = state_q;
        slice_d    = slice_q;
        len_d      = len_q;
        piece_d    = piece_q;
        remain_d   = remain_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        move_req_d = move_req_q;
        cut_req_d  = cut_req_q;
        err_d      = err_q;
        paused_eff = paused_q ^ pause_i;
        paused_d   = paused_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d   = 1'b0;
                    state_d = S_WAIT_DIST;
                end else if (slice_i) begin
                    slice_d = (slice_q == 5'(MAX_SLICE)) ? 5'd1 : slice_q + 5'd1;
                end
            end
            S_WAIT_DIST: begin
                if (distance_valid_i) begin
                    len_d   = distance_i;
                    rem_d   = '0;
                    piece_d = '0;
                    cnt_d   = CNT_W'(DIST_W - 1);
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d   = rem_next;
                piece_d = piece_shift;
                if (cnt_q == '0) begin
                    if (piece_shift == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        remain_d = slice_q;
                        state_d  = S_MOVE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MOVE: begin
                if (!paused_eff) begin
                    move_req_d = 1'b1;
                    state_d    = S_MOVE_WAIT;
                end
            end
            S_MOVE_WAIT: begin
                if (move_done_i) begin
                    move_req_d = 1'b0;
                    state_d    = S_CUT;
                end
            end
            S_CUT: begin
                if (!paused_eff) begin
                    cut_req_d = 1'b1;
                    state_d   = S_CUT_WAIT;
                end
            end
            S_CUT_WAIT: begin
                if (cut_done_i) begin
                    cut_req_d = 1'b0;
                    remain_d  = remain_q - 5'd1;
                    state_d   = (remain_q == 5'd1) ? S_DONE : S_MOVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_IDLE) begin
            paused_d = 1'b0;
        end else if (state_q != S_IDLE) begin
            paused_d = paused_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            slice_q    <= 5'd1;
            len_q      <= '0;
            piece_q    <= '0;
            remain_q   <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            move_req_q <= 1'b0;
            cut_req_q  <= 1'b0;
            paused_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slice_q    <= slice_d;
            len_q      <= len_d;
            piece_q    <= piece_d;
            remain_q   <= remain_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            move_req_q <= move_req_d;
            cut_req_q  <= cut_req_d;
            paused_q   <= paused_d;
            err_q      <= err_d;
        end
    end

    assign move_req_o   = move_req_q;
    assign move_steps_o = piece_q;
    assign cut_req_o    = cut_req_q;
    assign slice_num_o  = slice_q;
    assign busy_o       = (state_q != S_IDLE);
    assign paused_o     = paused_q;
    assign finish_o     = (state_q == S_DONE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_slice_sequencer.sv
module tb_slice_sequencer;

    localparam int DIST_W = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              pause_i = 1'b0;
    logic              slice_i = 1'b0;
    logic [DIST_W-1:0] distance_i = '0;
    logic              distance_valid_i = 1'b0;
    logic              move_req_o;
    logic [DIST_W-1:0] move_steps_o;
    logic              move_done_i = 1'b0;
    logic              cut_req_o;
    logic              cut_done_i = 1'b0;
    logic [4:0]        slice_num_o;
    logic              busy_o;
    logic              paused_o;
    logic              finish_o;
    logic              err_o;

    slice_sequencer #(.DIST_W(DIST_W), .MAX_SLICE(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .pause_i          (pause_i),
        .slice_i          (slice_i),
        .distance_i       (distance_i),
        .distance_valid_i (distance_valid_i),
        .move_req_o       (move_req_o),
        .move_steps_o     (move_steps_o),
        .move_done_i      (move_done_i),
        .cut_req_o        (cut_req_o),
        .cut_done_i       (cut_done_i),
        .slice_num_o      (slice_num_o),
        .busy_o           (busy_o),
        .paused_o         (paused_o),
        .finish_o         (finish_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    int   move_rises  = 0;
    int   cut_rises   = 0;
    int   finish_cnt  = 0;
    int   overlap_cnt = 0;
    logic mv_prev = 1'b0;
    logic ct_prev = 1'b0;

    always @(negedge clk) begin
        if (move_req_o && !mv_prev) move_rises++;
        if (cut_req_o && !ct_prev)  cut_rises++;
        if (finish_o)               finish_cnt++;
        if (move_req_o && cut_req_o) overlap_cnt++;
        mv_prev = move_req_o;
        ct_prev = cut_req_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_slice();
        slice_i = 1'b1; tick(); slice_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1; tick(); start_i = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_i = 1'b1; tick(); pause_i = 1'b0;
    endtask

    task automatic send_dist(input int d);
        distance_i = DIST_W'(d);
        distance_valid_i = 1'b1;
        tick();
        distance_valid_i = 1'b0;
    endtask

    task automatic wait_move();
        int n = 0;
        while (!move_req_o && n < 200) begin tick(); n++; end
        chk("move_req_seen", 32'(move_req_o), 32'd1);
    endtask

    task automatic wait_cut();
        int n = 0;
        while (!cut_req_o && n < 200) begin tick(); n++; end
        chk("cut_req_seen", 32'(cut_req_o), 32'd1);
    endtask

    task automatic wait_finish();
        int n = 0;
        while (!finish_o && n < 200) begin tick(); n++; end
        chk("finish_seen", 32'(finish_o), 32'd1);
    endtask

    task automatic do_pair(input int steps);
        wait_move();
        chk("move_steps", 32'(move_steps_o), 32'(steps));
        chk("no_cut_during_move", 32'(cut_req_o), 32'd0);
        move_done_i = 1'b1; tick(); move_done_i = 1'b0;
        chk("move_req_drop", 32'(move_req_o), 32'd0);
        wait_cut();
        cut_done_i = 1'b1; tick(); cut_done_i = 1'b0;
        chk("cut_req_drop", 32'(cut_req_o), 32'd0);
    endtask

    initial begin
        int mv0, ct0, f0, n;

        // Reset values
        tick(); tick();
        chk("rst_slice_num", 32'(slice_num_o), 32'd1);
        chk("rst_move_req",  32'(move_req_o),  32'd0);
        chk("rst_move_steps",32'(move_steps_o),32'd0);
        chk("rst_cut_req",   32'(cut_req_o),   32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_paused",    32'(paused_o),    32'd0);
        chk("rst_finish",    32'(finish_o),    32'd0);
        chk("rst_err",       32'(err_o),       32'd0);
        rst = 1'b0;
        tick();

        // Basic job: 4 slices of 1000 -> 250 each
        repeat (3) pulse_slice();
        chk("basic_slice_num", 32'(slice_num_o), 32'd4);
        pulse_pause();
        chk("idle_pause_ignored", 32'(paused_o), 32'd0);
        pulse_start();
        chk("basic_busy", 32'(busy_o), 32'd1);
        tick();
        send_dist(1000);
        for (int i = 0; i < 4; i++) do_pair(250);
        wait_finish();
        tick();
        chk("basic_finish_one_cycle", 32'(finish_o), 32'd0);
        chk("basic_idle", 32'(busy_o), 32'd0);
        chk("basic_moves", 32'(move_rises), 32'd4);
        chk("basic_cuts",  32'(cut_rises),  32'd4);
        chk("basic_finishes", 32'(finish_cnt), 32'd1);

        // Division timing: 100 / 3 = 33, first request DIST_W+1 cycles after capture
        repeat (15) pulse_slice();
        chk("div_slice_num", 32'(slice_num_o), 32'd3);
        pulse_start();
        send_dist(100);
        n = 0;
        while (!move_req_o && n < 200) begin tick(); n++; end
        chk("div_latency", 32'(n), 32'(DIST_W + 1));
        for (int i = 0; i < 3; i++) do_pair(33);
        wait_finish();
        tick();
        chk("div_moves", 32'(move_rises), 32'd7);

        // Pause: 300 / 3 = 100
        pulse_start();
        send_dist(300);
        do_pair(100);
        wait_move();
        chk("pause_steps", 32'(move_steps_o), 32'd100);
        pulse_pause();
        chk("pause_set", 32'(paused_o), 32'd1);
        chk("pause_move_held", 32'(move_req_o), 32'd1);
        move_done_i = 1'b1; tick(); move_done_i = 1'b0;
        chk("pause_move_drop", 32'(move_req_o), 32'd0);
        repeat (5) tick();
        chk("pause_cut_blocked", 32'(cut_req_o), 32'd0);
        chk("pause_busy", 32'(busy_o), 32'd1);
        pulse_pause();
        chk("unpause_cut_issued", 32'(cut_req_o), 32'd1);
        chk("unpause_flag", 32'(paused_o), 32'd0);
        cut_done_i = 1'b1; tick(); cut_done_i = 1'b0;
        pulse_pause();
        chk("pause_same_cycle_no_move", 32'(move_req_o), 32'd0);
        chk("pause_same_cycle_flag", 32'(paused_o), 32'd1);
        tick();
        chk("pause_still_blocked", 32'(move_req_o), 32'd0);
        pulse_pause();
        chk("unpause_move_issued", 32'(move_req_o), 32'd1);
        do_pair(100);
        wait_finish();
        tick();
        chk("pause_moves", 32'(move_rises), 32'd10);
        chk("pause_cuts",  32'(cut_rises),  32'd10);

        // Error path: 3 / 5 = 0
        repeat (2) pulse_slice();
        chk("err_slice_num", 32'(slice_num_o), 32'd5);
        mv0 = move_rises; ct0 = cut_rises; f0 = finish_cnt;
        pulse_start();
        send_dist(3);
        wait_finish();
        chk("err_set", 32'(err_o), 32'd1);
        tick();
        chk("err_no_moves", 32'(move_rises), 32'(mv0));
        chk("err_no_cuts",  32'(cut_rises),  32'(ct0));
        chk("err_one_finish", 32'(finish_cnt), 32'(f0 + 1));
        chk("err_held_idle", 32'(err_o), 32'd1);
        pulse_start();
        chk("err_cleared", 32'(err_o), 32'd0);

        // Lockout while busy
        pulse_slice();
        chk("lock_slice", 32'(slice_num_o), 32'd5);
        pulse_start();
        chk("lock_busy", 32'(busy_o), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("lock_rst_slice", 32'(slice_num_o), 32'd1);
        chk("lock_rst_busy", 32'(busy_o), 32'd0);

        // Wrap
        repeat (15) pulse_slice();
        chk("wrap_max", 32'(slice_num_o), 32'd16);
        pulse_slice();
        chk("wrap_to_one", 32'(slice_num_o), 32'd1);

        // Reset mid CUT_WAIT: 40 / 2 = 20
        pulse_slice();
        pulse_start();
        send_dist(40);
        wait_move();
        chk("rst_job_steps", 32'(move_steps_o), 32'd20);
        move_done_i = 1'b1; tick(); move_done_i = 1'b0;
        wait_cut();
        f0 = finish_cnt; mv0 = move_rises;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_cut_drop", 32'(cut_req_o), 32'd0);
        chk("midrst_slice", 32'(slice_num_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        cut_done_i = 1'b1; tick(); cut_done_i = 1'b0;
        repeat (3) tick();
        chk("late_done_cut", 32'(cut_req_o), 32'd0);
        chk("late_done_busy", 32'(busy_o), 32'd0);
        chk("midrst_no_finish", 32'(finish_cnt), 32'(f0));
        chk("midrst_no_move", 32'(move_rises), 32'(mv0));

        chk("req_overlap", 32'(overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
